// File: rtl/udp_pixel_depacketizer_if.sv
// Byte stream in from the UDP receive path and pixel writes out to the frame RAM.
// The depacketizer connects through the slave modport.
interface udp_pixel_depacketizer_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        Rx_Data;
  logic              Rx_Valid;
  logic              Rx_Ready;
  logic              Rx_Last;
  logic              Pix_WrEn;
  logic [ADDR_W-1:0] Pix_Addr;
  logic [23:0]       Pix_Data;
  logic              Frame_Commit;

  modport master (
    output Rx_Data, Rx_Valid, Rx_Last,
    input  Rx_Ready, Pix_WrEn, Pix_Addr, Pix_Data, Frame_Commit
  );

  modport slave (
    input  Rx_Data, Rx_Valid, Rx_Last,
    output Rx_Ready, Pix_WrEn, Pix_Addr, Pix_Data, Frame_Commit
  );
endinterface

// File: rtl/udp_pixel_depacketizer.sv
// Parses one LED pixel packet per UDP datagram into frame RAM writes.
// Header: MAGIC, flags (bit0 = commit), start index S, count N, then N RGB triples.
//
//  state   | meaning
//  HDR     | collecting header bytes B0..B5 (idx)
//  PAYLOAD | collecting R,G,B triples (col), pixel counter k
//  DROP    | discarding bytes until Rx_Last, then count an error
module udp_pixel_depacketizer #(
  parameter int          NUM_PIXELS = 1024,
  parameter int          ADDR_W     = 10,
  parameter logic [7:0]  MAGIC      = 8'hA5
) (
  input  logic                        Clk,
  input  logic                        Reset,
  udp_pixel_depacketizer_if.slave     bus,
  output logic [15:0]                 Pkt_Count,
  output logic [15:0]                 Err_Count
);

  typedef enum logic [1:0] {HDR, PAYLOAD, DROP} state_t;

  state_t      state, state_n;
  logic [2:0]  idx, idx_n;
  logic [1:0]  col, col_n;
  logic [15:0] k, k_n;
  logic [15:0] start_idx;
  logic [15:0] n_cnt;
  logic [7:0]  n_hi;
  logic [7:0]  red, green;
  logic        commit_flag;
  logic        beat, last;
  logic        good, bad, wr_pix;
  logic [15:0] n_full;
  logic [16:0] pix_idx;

  assign beat    = bus.Rx_Valid & bus.Rx_Ready;
  assign last    = bus.Rx_Last;
  assign n_full  = {n_hi, bus.Rx_Data};
  // 17 bits so that S+k never wraps back into the valid address range
  assign pix_idx = {1'b0, start_idx} + {1'b0, k};

  always_comb begin
    state_n = state;
    idx_n   = idx;
    col_n   = col;
    k_n     = k;
    good    = 1'b0;
    bad     = 1'b0;
    wr_pix  = 1'b0;
    if (beat) begin
      case (state)
        HDR: begin
          idx_n = idx + 3'd1;
          if (idx == 3'd0 && bus.Rx_Data != MAGIC) begin
            idx_n = 3'd0;
            if (last) bad = 1'b1;
            else      state_n = DROP;
          end else if (idx == 3'd5) begin
            idx_n = 3'd0;
            if (n_full == 16'd0) begin
              if (last) good = 1'b1;
              else      state_n = DROP;
            end else if (last) begin
              bad = 1'b1;
            end else begin
              state_n = PAYLOAD;
              col_n   = 2'd0;
              k_n     = 16'd0;
            end
          end else if (last) begin
            bad   = 1'b1;
            idx_n = 3'd0;
          end
        end
        PAYLOAD: begin
          if (col == 2'd2) begin
            wr_pix = 1'b1;
            col_n  = 2'd0;
            k_n    = k + 16'd1;
            if (k == n_cnt - 16'd1) begin
              if (last) begin
                good    = 1'b1;
                state_n = HDR;
              end else begin
                state_n = DROP;
              end
            end else if (last) begin
              bad     = 1'b1;
              state_n = HDR;
            end
          end else begin
            col_n = col + 2'd1;
            if (last) begin
              bad     = 1'b1;
              state_n = HDR;
            end
          end
        end
        DROP: begin
          if (last) begin
            bad     = 1'b1;
            state_n = HDR;
          end
        end
        default: state_n = HDR;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state            <= HDR;
      idx              <= 3'd0;
      col              <= 2'd0;
      k                <= 16'd0;
      start_idx        <= 16'd0;
      n_cnt            <= 16'd0;
      n_hi             <= 8'd0;
      red              <= 8'd0;
      green            <= 8'd0;
      commit_flag      <= 1'b0;
      bus.Rx_Ready     <= 1'b0;
      bus.Pix_WrEn     <= 1'b0;
      bus.Pix_Addr     <= '0;
      bus.Pix_Data     <= 24'd0;
      bus.Frame_Commit <= 1'b0;
      Pkt_Count        <= 16'd0;
      Err_Count        <= 16'd0;
    end else begin
      state            <= state_n;
      idx              <= idx_n;
      col              <= col_n;
      k                <= k_n;
      bus.Rx_Ready     <= 1'b1;
      bus.Pix_WrEn     <= wr_pix && (pix_idx < 17'(NUM_PIXELS));
      bus.Frame_Commit <= good & commit_flag;
      if (beat && state == HDR) begin
        case (idx)
          3'd1:    commit_flag     <= bus.Rx_Data[0];
          3'd2:    start_idx[15:8] <= bus.Rx_Data;
          3'd3:    start_idx[7:0]  <= bus.Rx_Data;
          3'd4:    n_hi            <= bus.Rx_Data;
          3'd5:    n_cnt           <= n_full;
          default: ;
        endcase
      end
      if (beat && state == PAYLOAD) begin
        if (col == 2'd0) red   <= bus.Rx_Data;
        if (col == 2'd1) green <= bus.Rx_Data;
      end
      if (wr_pix && (pix_idx < 17'(NUM_PIXELS))) begin
        bus.Pix_Addr <= pix_idx[ADDR_W-1:0];
        bus.Pix_Data <= {red, green, bus.Rx_Data};
      end
      if (good) Pkt_Count <= Pkt_Count + 16'd1;
      if (bad && Err_Count != 16'hFFFF) Err_Count <= Err_Count + 16'd1;
    end
  end

endmodule

// File: tb/tb_udp_pixel_depacketizer.sv
// Directed vector bench for udp_pixel_depacketizer: packet table plus
// back-to-back, reset-mid-packet and error-saturation sequences.
module tb_udp_pixel_depacketizer;

  typedef struct packed {
    int           len;
    logic [127:0] b;
    int           gap;
    int           nwr;
    logic [9:0]   a0;
    logic [23:0]  d0;
    logic [9:0]   a1;
    logic [23:0]  d1;
    logic         commit;
    int           dpkt;
    int           derr;
  } vec_t;

  logic        Clk;
  logic        Reset;
  logic [15:0] Pkt_Count;
  logic [15:0] Err_Count;

  udp_pixel_depacketizer_if #(.ADDR_W(10)) bus ();

  udp_pixel_depacketizer dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus),
    .Pkt_Count (Pkt_Count),
    .Err_Count (Err_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          acc[16];
  logic [33:0] wq[$];
  int          wcyc[$];
  int          commit_cnt = 0;
  int          commit_cyc = -1;

  always @(negedge Clk) begin
    if (bus.Pix_WrEn === 1'b1) begin
      wq.push_back({bus.Pix_Addr, bus.Pix_Data});
      wcyc.push_back(cyc);
    end
    if (bus.Frame_Commit === 1'b1) begin
      commit_cnt = commit_cnt + 1;
      commit_cyc = cyc;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int len, input logic [127:0] b, input int gap, input int nwr,
                              input logic [9:0] a0, input logic [23:0] d0,
                              input logic [9:0] a1, input logic [23:0] d1,
                              input logic commit, input int dpkt, input int derr);
    vec_t v;
    v.len = len; v.b = b; v.gap = gap; v.nwr = nwr;
    v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    v.commit = commit; v.dpkt = dpkt; v.derr = derr;
    return v;
  endfunction

  task automatic idle(input int n);
    bus.Rx_Valid = 1'b0;
    bus.Rx_Last  = 1'b0;
    repeat (n) @(negedge Clk);
  endtask

  // Called at a negedge; returns at a negedge with the last byte accepted.
  task automatic send(input vec_t v);
    for (int i = 0; i < v.len; i++) begin
      if (v.gap > 0 && i > 0) begin
        bus.Rx_Valid = 1'b0;
        repeat (v.gap) @(negedge Clk);
      end
      bus.Rx_Valid = 1'b1;
      bus.Rx_Data  = v.b[127-8*i -: 8];
      bus.Rx_Last  = (i == v.len - 1);
      @(posedge Clk);
      #1 acc[i] = cyc;
      @(negedge Clk);
    end
    bus.Rx_Valid = 1'b0;
    bus.Rx_Last  = 1'b0;
  endtask

  task automatic clear_mon();
    wq.delete();
    wcyc.delete();
    commit_cnt = 0;
    commit_cyc = -1;
  endtask

  task automatic check_vec(input vec_t v, input string tag, input logic [15:0] p0, input logic [15:0] e0);
    chk({tag, " nwr"}, 64'(wq.size()), 64'(v.nwr));
    for (int j = 0; j < v.nwr && j < wq.size(); j++) begin
      chk($sformatf("%s addr%0d", tag, j), 64'(wq[j][33:24]), 64'(j == 0 ? v.a0 : v.a1));
      chk($sformatf("%s data%0d", tag, j), 64'(wq[j][23:0]),  64'(j == 0 ? v.d0 : v.d1));
      chk($sformatf("%s wcyc%0d", tag, j), 64'(wcyc[j]),      64'(acc[8+3*j]));
    end
    chk({tag, " commits"}, 64'(commit_cnt), 64'(v.commit ? 1 : 0));
    if (v.commit && commit_cnt == 1)
      chk({tag, " commit_cyc"}, 64'(commit_cyc), 64'(acc[v.len-1]));
    chk({tag, " pkt_delta"}, 64'(16'(Pkt_Count - p0)), 64'(v.dpkt));
    chk({tag, " err_delta"}, 64'(16'(Err_Count - e0)), 64'(v.derr));
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [15:0] p0, e0;
    clear_mon();
    p0 = Pkt_Count;
    e0 = Err_Count;
    send(v);
    idle(3);
    check_vec(v, $sformatf("vec%0d", id), p0, e0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " rx_ready"}, 64'(bus.Rx_Ready), 64'(0));
    chk({tag, " wr_en"},    64'(bus.Pix_WrEn), 64'(0));
    chk({tag, " addr"},     64'(bus.Pix_Addr), 64'(0));
    chk({tag, " data"},     64'(bus.Pix_Data), 64'(0));
    chk({tag, " commit"},   64'(bus.Frame_Commit), 64'(0));
    chk({tag, " pkt"},      64'(Pkt_Count), 64'(0));
    chk({tag, " err"},      64'(Err_Count), 64'(0));
  endtask

  vec_t vecs[$];
  vec_t v1;
  logic [15:0] p0, e0;

  initial begin
    vecs.push_back(mk(12, 128'hA501_0000_0002_1122_3344_5566_0000_0000, 0, 2, 10'h000, 24'h112233, 10'h001, 24'h445566, 1, 1, 0));
    vecs.push_back(mk(12, 128'hA500_0000_0002_1122_3344_5566_0000_0000, 2, 2, 10'h000, 24'h112233, 10'h001, 24'h445566, 0, 1, 0));
    vecs.push_back(mk(10, 128'h5A01_0203_0405_0607_0809_0000_0000_0000, 0, 0, 10'h000, 24'h0,      10'h000, 24'h0,      0, 0, 1));
    vecs.push_back(mk(12, 128'hA501_0000_0002_1122_3344_5566_0000_0000, 0, 2, 10'h000, 24'h112233, 10'h001, 24'h445566, 1, 1, 0));
    vecs.push_back(mk(12, 128'hA501_03FF_0002_AABB_CCDD_EEFF_0000_0000, 0, 1, 10'h3FF, 24'hAABBCC, 10'h000, 24'h0,      1, 1, 0));
    vecs.push_back(mk(11, 128'hA500_0010_0002_0102_0304_0500_0000_0000, 0, 1, 10'h010, 24'h010203, 10'h000, 24'h0,      0, 0, 1));
    vecs.push_back(mk(10, 128'hA501_0020_0001_0708_090A_0000_0000_0000, 0, 1, 10'h020, 24'h070809, 10'h000, 24'h0,      0, 0, 1));
    vecs.push_back(mk(6,  128'hA501_0000_0000_0000_0000_0000_0000_0000, 0, 0, 10'h000, 24'h0,      10'h000, 24'h0,      1, 1, 0));
    vecs.push_back(mk(3,  128'hA501_0000_0000_0000_0000_0000_0000_0000, 0, 0, 10'h000, 24'h0,      10'h000, 24'h0,      0, 0, 1));
    vecs.push_back(mk(8,  128'hA500_0000_0000_1234_0000_0000_0000_0000, 0, 0, 10'h000, 24'h0,      10'h000, 24'h0,      0, 0, 1));
    vecs.push_back(mk(6,  128'hA500_0005_0001_0000_0000_0000_0000_0000, 0, 0, 10'h000, 24'h0,      10'h000, 24'h0,      0, 0, 1));
    vecs.push_back(mk(9,  128'hA501_0040_0001_C0FF_EE00_0000_0000_0000, 3, 1, 10'h040, 24'hC0FFEE, 10'h000, 24'h0,      1, 1, 0));
    vecs.push_back(mk(1,  128'h3300_0000_0000_0000_0000_0000_0000_0000, 0, 0, 10'h000, 24'h0,      10'h000, 24'h0,      0, 0, 1));
    vecs.push_back(mk(12, 128'hA501_FFFF_0002_0102_0304_0506_0000_0000, 0, 0, 10'h000, 24'h0,      10'h000, 24'h0,      1, 1, 0));
    vecs.push_back(mk(9,  128'hA502_0001_0001_ABCD_EF00_0000_0000_0000, 0, 1, 10'h001, 24'hABCDEF, 10'h000, 24'h0,      0, 1, 0));

    Reset        = 1'b1;
    bus.Rx_Valid = 1'b0;
    bus.Rx_Last  = 1'b0;
    bus.Rx_Data  = 8'h00;
    repeat (3) @(negedge Clk);
    check_reset_outputs("init");
    Reset = 1'b0;
    @(negedge Clk);
    chk("init rx_ready_after", 64'(bus.Rx_Ready), 64'(1));

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Two datagrams with no idle cycle between them
    v1 = vecs[0];
    clear_mon();
    p0 = Pkt_Count;
    e0 = Err_Count;
    send(v1);
    send(v1);
    idle(3);
    chk("b2b nwr",       64'(wq.size()), 64'(4));
    if (wq.size() == 4) begin
      chk("b2b addr2",   64'(wq[2][33:24]), 64'(10'h000));
      chk("b2b data3",   64'(wq[3][23:0]),  64'(24'h445566));
      chk("b2b wcyc3",   64'(wcyc[3]),      64'(acc[11]));
    end
    chk("b2b commits",   64'(commit_cnt), 64'(2));
    chk("b2b pkt_delta", 64'(16'(Pkt_Count - p0)), 64'(2));
    chk("b2b err_delta", 64'(16'(Err_Count - e0)), 64'(0));

    // Reset in the middle of pixel 1 of a packet
    v1 = vecs[0];
    v1.len = 10;
    send(v1);
    Reset = 1'b1;
    idle(2);
    check_reset_outputs("rst_mid");
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_mid rx_ready_after", 64'(bus.Rx_Ready), 64'(1));
    run_vec(vecs[0], 100);
    chk("rst_mid pkt_abs", 64'(Pkt_Count), 64'(1));

    // Error counter saturation: 65535 single-byte bad datagrams, then one more
    Reset = 1'b1;
    idle(2);
    Reset = 1'b0;
    @(negedge Clk);
    bus.Rx_Valid = 1'b1;
    bus.Rx_Last  = 1'b1;
    bus.Rx_Data  = 8'h33;
    repeat (65535) @(posedge Clk);
    @(negedge Clk);
    bus.Rx_Valid = 1'b0;
    bus.Rx_Last  = 1'b0;
    chk("sat err_full", 64'(Err_Count), 64'(16'hFFFF));
    v1 = vecs[12];
    send(v1);
    idle(2);
    chk("sat err_hold", 64'(Err_Count), 64'(16'hFFFF));
    chk("sat pkt",      64'(Pkt_Count), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
